// File: rtl/mac_requant_pkg.sv
// Shared types and constants for the MAC requantization stage.
// The ReLU clamp is selected at build time by MAC_REQUANT_RELU_EN.
package mac_requant_pkg;

    localparam int ACC_W     = 21;
    localparam int SHIFT_MAX = 21;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [15:0]      bias_t;
    typedef logic signed [7:0]       q8_t;

    localparam q8_t Q8_MAX = 8'sd127;
    localparam q8_t Q8_MIN = -8'sd128;

    function automatic q8_t sat_q8(input logic signed [63:0] v);
        q8_t r;
        if (v > 64'(Q8_MAX)) begin
            r = Q8_MAX;
        end else if (v < 64'(Q8_MIN)) begin
            r = Q8_MIN;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_requant_fifo.sv
// Output FIFO for requantized bytes; push is accepted when full if a pop
// happens on the same edge, so a full FIFO can stream without losing a slot.
module mac_requant_fifo
    import mac_requant_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  q8_t                      din,
    input  logic                     pop,
    output q8_t                      dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    q8_t            mem_q [DEPTH];
    q8_t            mem_d [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt_q;
    assign dout    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_requant.sv
// Bias add, rounding shift and int8 saturation of MAC results into an output FIFO.
// Define MAC_REQUANT_RELU_EN to clamp negative results to zero before saturation.
module mac_requant #(
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_W      = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] in_data,
    input  logic signed [15:0]      bias,
    input  logic [4:0]              shift,
    output logic                    up_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_data,
    output logic                    overflow
);

    import mac_requant_pkg::*;

    localparam int SW = ACC_W + 1;
    localparam int RW = ACC_W + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [SW-1:0] sum1_q, sum1_d;
    logic [4:0]           sh1_q, sh1_d;
    logic signed [RW-1:0] shr2_q, shr2_d;
    q8_t                  q3_q, q3_d;
    logic                 ovf_q, ovf_d;

    logic [CW-1:0]        fifo_count;
    logic                 fifo_full, fifo_empty;
    q8_t                  fifo_dout;
    logic [CW:0]          occupancy;
    logic                 accept, drop, push;
    logic signed [RW-1:0] rnd, relu_v;

    // Every result already in the pipeline holds a reserved FIFO slot, so
    // pushes from S3 can never find the FIFO full.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(v1_q) + (CW+1)'(v2_q) + (CW+1)'(v3_q);
    assign up_ready  = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign accept    = en && in_valid && up_ready;
    assign drop      = en && in_valid && !up_ready;
    assign push      = en && v3_q;

    assign rnd = (sh1_q == 5'd0) ? '0 : (RW'(1) <<< (sh1_q - 5'd1));

`ifdef MAC_REQUANT_RELU_EN
    assign relu_v = shr2_q[RW-1] ? '0 : shr2_q;
`else
    assign relu_v = shr2_q;
`endif

    always_comb begin
        v1_d   = v1_q;
        v2_d   = v2_q;
        v3_d   = v3_q;
        sum1_d = sum1_q;
        sh1_d  = sh1_q;
        shr2_d = shr2_q;
        q3_d   = q3_q;
        ovf_d  = ovf_q | drop;
        if (en) begin
            v1_d   = accept;
            v2_d   = v1_q;
            v3_d   = v2_q;
            sum1_d = SW'(in_data) + SW'(bias);
            sh1_d  = (shift > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : shift;
            shr2_d = (RW'(sum1_q) + rnd) >>> sh1_q;
            q3_d   = sat_q8(64'(relu_v));
        end
        if (clr) begin
            v1_d  = 1'b0;
            v2_d  = 1'b0;
            v3_d  = 1'b0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            sum1_q <= '0;
            sh1_q  <= '0;
            shr2_q <= '0;
            q3_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            sum1_q <= sum1_d;
            sh1_q  <= sh1_d;
            shr2_q <= shr2_d;
            q3_q   <= q3_d;
            ovf_q  <= ovf_d;
        end
    end

    mac_requant_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .din   (q3_q),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_dout;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_requant.sv
// Self-checking bench for mac_requant: fixed vectors, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mac_requant;

    localparam int DEPTH = 4;
    localparam int ACC_W = 21;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    en = 1'b0;
    logic                    clr = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [ACC_W-1:0] in_data = '0;
    logic signed [15:0]      bias = '0;
    logic [4:0]              shift = '0;
    logic                    out_ready = 1'b0;
    logic                    up_ready;
    logic                    out_valid;
    logic signed [7:0]       out_data;
    logic                    overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: FIFO contents, in-flight results with their age.
    logic [7:0] exp_q[$];
    int         inf_val[$];
    int         inf_age[$];
    bit         exp_ovf;

    typedef struct {
        int d;
        int b;
        int s;
        int e_lin;
        int e_relu;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    mac_requant #(
        .FIFO_DEPTH (DEPTH),
        .ACC_W      (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .bias      (bias),
        .shift     (shift),
        .up_ready  (up_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    function automatic int ref_q(input int d, input int b, input int s);
        longint v;
        int     sc;
        sc = (s > 21) ? 21 : s;
        v  = longint'(d) + longint'(b);
        if (sc > 0) v = v + (longint'(1) << (sc - 1));
        v = v >>> sc;
`ifdef MAC_REQUANT_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        inf_val.delete();
        inf_age.delete();
        exp_ovf = 1'b0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance both.
    task automatic cycle(input bit e, input bit c, input bit iv, input int d, input int b,
                         input int s, input bit ordy);
        bit ur;
        en        = e;
        clr       = c;
        in_valid  = iv;
        in_data   = d[ACC_W-1:0];
        bias      = b[15:0];
        shift     = s[4:0];
        out_ready = ordy;
        #1;
        ur = (exp_q.size() + inf_val.size()) < DEPTH;
        chk("up_ready", up_ready, ur);
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) chk("out_data", out_data, $signed(exp_q[0]));
        chk("overflow", overflow, exp_ovf);
        if (c) begin
            model_clear();
        end else begin
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            if (e) begin
                if (inf_val.size() > 0 && inf_age[0] == 2) begin
                    exp_q.push_back(8'(inf_val.pop_front()));
                    void'(inf_age.pop_front());
                end
                foreach (inf_age[i]) inf_age[i]++;
                if (iv) begin
                    if (ur) begin
                        inf_val.push_back(ref_q(d, b, s));
                        inf_age.push_back(0);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, ordy);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_up_ready", up_ready, 1);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int rnd_data();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 4000)) - 2000;
        return int'($urandom_range(0, 2097151)) - 1048576;
    endfunction

    task automatic random_phase(input int n, input int ordy_pct);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 1) == 1,
                  rnd_data(),
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < ordy_pct);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dv[4];
        tbl[0] = '{1000, 24, 4, 64, 64};
        tbl[1] = '{100000, 0, 2, 127, 127};
        tbl[2] = '{-100000, 0, 2, -128, 0};
        tbl[3] = '{-24, 0, 4, -1, 0};
        tbl[4] = '{-300, 0, 0, -128, 0};
        tbl[5] = '{1048575, 32767, 31, 1, 1};
        tbl[6] = '{8, 0, 4, 1, 1};
        tbl[7] = '{-8, 0, 4, 0, 0};
        tbl[8] = '{0, -32768, 8, -128, 0};
        tbl[9] = '{5000, -1000, 5, 125, 125};

        #1;
        apply_reset();

        // Fixed vectors: value and three-edge latency with an empty FIFO.
        foreach (tbl[i]) begin
            cycle(1'b1, 1'b0, 1'b1, tbl[i].d, tbl[i].b, tbl[i].s, 1'b1);
            n = 0;
            while (!out_valid && n < 10) begin
                cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
                n++;
            end
            chk("latency", n, 3);
`ifdef MAC_REQUANT_RELU_EN
            chk("tbl_data", out_data, tbl[i].e_relu);
`else
            chk("tbl_data", out_data, tbl[i].e_lin);
`endif
        end
        idle(2, 1'b1);

        // Credit exhaustion, drop with overflow, then in-order drain.
        for (int k = 0; k < 4; k++) begin
            dv[k] = 1000 * (k + 1) - 2500;
            cycle(1'b1, 1'b0, 1'b1, dv[k], 0, 4, 1'b0);
        end
        chk("credit_up_ready", up_ready, 0);
        cycle(1'b1, 1'b0, 1'b1, 777, 0, 0, 1'b0);
        chk("drop_overflow", overflow, 1);
        idle(3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", out_data, ref_q(dv[k], 0, 4));
            cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        end
        chk("drained", out_valid, 0);
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);

        // Full FIFO streaming: pops free credit, new results follow in order.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 40 * k + 3, 0, 0, 1'b0);
        idle(3, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b1, -17 * k, 5, 1, 1'b1);
        idle(6, 1'b1);

        // en low freezes the pipeline but pops continue.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 90 + k, 0, 0, 1'b0);
        idle(1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 5, 0, 0, 1'b1);
        idle(5, 1'b1);

        // clr with two results in flight, in_valid asserted alongside.
        cycle(1'b1, 1'b0, 1'b1, 100, 0, 0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 101, 0, 0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 102, 0, 0, 1'b0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_up_ready", up_ready, 1);
        chk("clr_overflow", overflow, 0);
        idle(5, 1'b1);

        // Asynchronous reset with two results in flight.
        cycle(1'b1, 1'b0, 1'b1, 200, 0, 0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 201, 0, 0, 1'b1);
        apply_reset();
        idle(6, 1'b1);

        random_phase(400, 75);
        random_phase(400, 20);
        idle(8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
